mc_control: RTL and testbench

MC_CONTROL -- requirements
Module: mc_control

---
 rtl/mc_control_pkg.sv | 48 ++++
 rtl/mc_control_decoder.sv | 61 ++++++
 rtl/mc_control.sv | 176 +++++++++++++++++
 tb/tb_mc_control.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_control_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, ALU codes,
// instruction fields, fault codes and the default memory timeout.
package mc_control_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    CL_NONE, CL_R, CL_ORI, CL_LB, CL_SB, CL_BNE
  } iclass_t;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0100;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [2:0] F3_SRL    = 3'b101;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_AND    = 3'b111;
  localparam logic [2:0] F3_LB     = 3'b000;
  localparam logic [2:0] F3_SB     = 3'b000;
  localparam logic [2:0] F3_BNE    = 3'b001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

  localparam int unsigned MEM_TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/mc_control_decoder.sv
// Instruction classifier: maps the IR word to a class, its EXEC alu_op,
// and the illegal / halt (all-zero word) flags.
module mc_decoder
  import mc_control_pkg::*;
(
  input  logic [31:0] instrucao,
  output iclass_t     cls,
  output logic [3:0]  alu_op,
  output logic        illegal,
  output logic        halt
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;

  assign opcode = instrucao[6:0];
  assign f3     = instrucao[14:12];
  assign f7     = instrucao[31:25];

  always_comb begin
    cls     = CL_NONE;
    alu_op  = ALU_ADD;
    halt    = (instrucao == '0);
    illegal = 1'b0;
    if (!halt) begin
      case (opcode)
        OP_RTYPE: begin
          cls = CL_R;
          if (f3 == F3_ADDSUB && f7 == F7_BASE)     alu_op = ALU_ADD;
          else if (f3 == F3_ADDSUB && f7 == F7_SUB) alu_op = ALU_SUB;
          else if (f3 == F3_SRL && f7 == F7_BASE)   alu_op = ALU_SRL;
          else if (f3 == F3_OR)                     alu_op = ALU_OR;
          else if (f3 == F3_AND)                    alu_op = ALU_AND;
          else begin
            cls     = CL_NONE;
            illegal = 1'b1;
          end
        end
        OP_IMM: begin
          if (f3 == F3_OR) begin cls = CL_ORI; alu_op = ALU_OR; end
          else illegal = 1'b1;
        end
        OP_LOAD: begin
          if (f3 == F3_LB) cls = CL_LB;
          else illegal = 1'b1;
        end
        OP_STORE: begin
          if (f3 == F3_SB) cls = CL_SB;
          else illegal = 1'b1;
        end
        OP_BRANCH: begin
          if (f3 == F3_BNE) begin cls = CL_BNE; alu_op = ALU_SUB; end
          else illegal = 1'b1;
        end
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/mc_control.sv
// Multicycle control FSM (IDLE/FETCH/DECODE/EXEC/MEM/WB/HALT) with memory
// timeout fault. Define CONTROL_PERF_EN to add cycle_count/instr_count.
module mc_control
  import mc_control_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] instrucao,
  input  logic        mem_ready,
  input  logic        zero,
  output logic        pc_write,
  output logic        pc_src,
  output logic        ir_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_addr_src,
  output logic        reg_write,
  output logic        wb_src,
  output logic        alu_src_b,
  output logic        imm_en,
  output logic        busy,
  output logic [3:0]  alu_op,
  output logic [2:0]  state,
  output logic [1:0]  fault
`ifdef CONTROL_PERF_EN
  ,
  output logic [31:0] cycle_count,
  output logic [31:0] instr_count
`endif
);

  localparam int unsigned CW = $clog2(MEM_TIMEOUT + 1);

  state_t      state_q;
  logic [CW-1:0] wait_cnt;
  iclass_t     cls;
  logic [3:0]  dec_alu;
  logic        illegal;
  logic        halt;
  logic        timeout;

  mc_decoder u_dec (
    .instrucao (instrucao),
    .cls       (cls),
    .alu_op    (dec_alu),
    .illegal   (illegal),
    .halt      (halt)
  );

  assign state   = state_q;
  assign timeout = !mem_ready && (wait_cnt == CW'(MEM_TIMEOUT - 1));

  // wait_cnt is cleared on every state change so FETCH and MEM waits never accumulate
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      fault    <= FAULT_NONE;
      wait_cnt <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (start) state_q <= S_FETCH;
        S_FETCH, S_MEM: begin
          if (mem_ready) begin
            wait_cnt <= '0;
            if (state_q == S_FETCH)  state_q <= S_DECODE;
            else if (cls == CL_LB)   state_q <= S_WB;
            else                     state_q <= S_FETCH;
          end else if (timeout) begin
            wait_cnt <= '0;
            state_q  <= S_HALT;
            fault    <= FAULT_TIMEOUT;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        S_DECODE: begin
          if (halt) state_q <= S_HALT;
          else if (illegal) begin
            state_q <= S_HALT;
            fault   <= FAULT_ILLEGAL;
          end else state_q <= S_EXEC;
        end
        S_EXEC: begin
          case (cls)
            CL_R, CL_ORI: state_q <= S_WB;
            CL_LB, CL_SB: state_q <= S_MEM;
            CL_BNE:       state_q <= S_FETCH;
            default: begin
              state_q <= S_HALT;
              fault   <= FAULT_ILLEGAL;
            end
          endcase
        end
        S_WB:    state_q <= S_FETCH;
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    pc_write     = 1'b0;
    pc_src       = 1'b0;
    ir_write     = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_addr_src = 1'b0;
    reg_write    = 1'b0;
    wb_src       = 1'b0;
    alu_src_b    = 1'b0;
    imm_en       = 1'b0;
    busy         = 1'b0;
    alu_op       = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        busy     = 1'b1;
        mem_read = 1'b1;
        ir_write = mem_ready;
      end
      S_DECODE: begin
        busy   = 1'b1;
        imm_en = 1'b1;
      end
      S_EXEC: begin
        busy   = 1'b1;
        alu_op = dec_alu;
        case (cls)
          CL_ORI, CL_LB, CL_SB: alu_src_b = 1'b1;
          CL_BNE: begin
            pc_write = 1'b1;
            pc_src   = ~zero;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        busy         = 1'b1;
        mem_addr_src = 1'b1;
        if (cls == CL_LB) mem_read = 1'b1;
        else begin
          mem_write = 1'b1;
          pc_write  = mem_ready;
        end
      end
      S_WB: begin
        busy      = 1'b1;
        reg_write = 1'b1;
        wb_src    = (cls == CL_LB);
        pc_write  = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef CONTROL_PERF_EN
  logic enter_fetch;

  assign enter_fetch = (state_q == S_EXEC && cls == CL_BNE) ||
                       (state_q == S_MEM && mem_ready && cls != CL_LB) ||
                       (state_q == S_WB);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cycle_count <= '0;
      instr_count <= '0;
    end else begin
      if (busy && cycle_count != '1)        cycle_count <= cycle_count + 32'd1;
      if (enter_fetch && instr_count != '1) instr_count <= instr_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: directed per-cycle expectations are queued
// by the stimulus process and compared by a monitor on the falling edge.
module tb_mc_control;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] instrucao = '0;
  logic        mem_ready = 1'b0;
  logic        zero = 1'b0;
  logic        pc_write, pc_src, ir_write, mem_read, mem_write, mem_addr_src;
  logic        reg_write, wb_src, alu_src_b, imm_en, busy;
  logic [3:0]  alu_op;
  logic [2:0]  state;
  logic [1:0]  fault;
`ifdef CONTROL_PERF_EN
  logic [31:0] cycle_count, instr_count;
`endif

  mc_control #(.MEM_TIMEOUT(16)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .instrucao    (instrucao),
    .mem_ready    (mem_ready),
    .zero         (zero),
    .pc_write     (pc_write),
    .pc_src       (pc_src),
    .ir_write     (ir_write),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr_src (mem_addr_src),
    .reg_write    (reg_write),
    .wb_src       (wb_src),
    .alu_src_b    (alu_src_b),
    .imm_en       (imm_en),
    .busy         (busy),
    .alu_op       (alu_op),
    .state        (state),
    .fault        (fault)
`ifdef CONTROL_PERF_EN
    ,
    .cycle_count  (cycle_count),
    .instr_count  (instr_count)
`endif
  );

  always #5 clock = ~clock;

  // ctl bit order: pc_write pc_src ir_write mem_read mem_write mem_addr_src
  //                reg_write wb_src alu_src_b imm_en busy
  localparam logic [10:0] C_OFF   = 11'b00000000000;
  localparam logic [10:0] F_WAIT  = 11'b00010000001;
  localparam logic [10:0] F_RDY   = 11'b00110000001;
  localparam logic [10:0] DEC     = 11'b00000000011;
  localparam logic [10:0] EX_R    = 11'b00000000001;
  localparam logic [10:0] EX_I    = 11'b00000000101;
  localparam logic [10:0] EX_BT   = 11'b11000000001;
  localparam logic [10:0] EX_BN   = 11'b10000000001;
  localparam logic [10:0] M_LB    = 11'b00010100001;
  localparam logic [10:0] M_SB_W  = 11'b00001100001;
  localparam logic [10:0] M_SB_R  = 11'b10001100001;
  localparam logic [10:0] WB_LB   = 11'b10000011001;
  localparam logic [10:0] WB_ALU  = 11'b10000010001;

  localparam logic [31:0] I_ADD = 32'h00208033;
  localparam logic [31:0] I_SUB = 32'h40208033;
  localparam logic [31:0] I_SRL = 32'h0020D033;
  localparam logic [31:0] I_OR  = 32'h0020E033;
  localparam logic [31:0] I_AND = 32'h0020F033;
  localparam logic [31:0] I_ORI = 32'h0060E093;
  localparam logic [31:0] I_LB  = 32'h00010083;
  localparam logic [31:0] I_SB  = 32'h00110023;
  localparam logic [31:0] I_BNE = 32'h00209463;
  localparam logic [31:0] I_ILL = 32'h0000707F;

  typedef struct {
    string       tag;
    logic [2:0]  st;
    logic [10:0] ctl;
    logic [3:0]  alu;
    logic [1:0]  flt;
    bit          perf;
    logic [31:0] cyc;
    logic [31:0] ins;
  } exp_t;

  exp_t q[$];
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  bit          nxt_perf = 1'b0;
  logic [31:0] nxt_cyc = '0;
  logic [31:0] nxt_ins = '0;

  logic [10:0] act_ctl;
  assign act_ctl = {pc_write, pc_src, ir_write, mem_read, mem_write, mem_addr_src,
                    reg_write, wb_src, alu_src_b, imm_en, busy};

  task automatic check(input string tag, input string what,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %0h expected %0h", tag, what, act, exp);
    end
  endtask

  // monitor: compare whatever expectation the stimulus queued for this cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (q.size() > 0) begin
        e = q.pop_front();
        check(e.tag, "state", 32'(state), 32'(e.st));
        check(e.tag, "ctl", 32'(act_ctl), 32'(e.ctl));
        check(e.tag, "alu_op", 32'(alu_op), 32'(e.alu));
        check(e.tag, "fault", 32'(fault), 32'(e.flt));
`ifdef CONTROL_PERF_EN
        if (e.perf) begin
          check(e.tag, "cycle_count", cycle_count, e.cyc);
          check(e.tag, "instr_count", instr_count, e.ins);
        end
`endif
      end
    end
  end

  task automatic push(input string tag, input logic [2:0] es, input logic [10:0] ec,
                      input logic [3:0] ea, input logic [1:0] ef);
    exp_t e;
    e.tag = tag; e.st = es; e.ctl = ec; e.alu = ea; e.flt = ef;
    e.perf = nxt_perf; e.cyc = nxt_cyc; e.ins = nxt_ins;
    nxt_perf = 1'b0;
    q.push_back(e);
  endtask

  task automatic step(input string tag, input bit st, input logic [31:0] ins,
                      input bit rdy, input bit z, input logic [2:0] es,
                      input logic [10:0] ec, input logic [3:0] ea, input logic [1:0] ef);
    @(posedge clock); #1;
    start = st; instrucao = ins; mem_ready = rdy; zero = z;
    push(tag, es, ec, ea, ef);
  endtask

  // reset held with start=1 to show reset dominates
  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b0; start = 1'b1; mem_ready = 1'b1;
    push("reset", 3'd0, C_OFF, 4'd0, 2'd0);
    @(posedge clock); #1;
    reset = 1'b1; start = 1'b0; mem_ready = 1'b0;
  endtask

  // one ALU-class instruction from FETCH back to FETCH, immediate memory
  task automatic run_alu(input string tag, input logic [31:0] ins,
                         input logic [10:0] exc, input logic [3:0] ea);
    step({tag, "_f"}, 0, ins, 1, 0, 3'd1, F_RDY, 4'd0, 2'd0);
    step({tag, "_d"}, 0, ins, 1, 0, 3'd2, DEC, 4'd0, 2'd0);
    step({tag, "_e"}, 0, ins, 1, 0, 3'd3, exc, ea, 2'd0);
    step({tag, "_w"}, 0, ins, 1, 0, 3'd5, WB_ALU, 4'd0, 2'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rins [4];
    logic [3:0]  ralu [4];
    rins[0] = I_SUB; rins[1] = I_SRL; rins[2] = I_OR; rins[3] = I_AND;
    ralu[0] = 4'b0001; ralu[1] = 4'b0100; ralu[2] = 4'b0011; ralu[3] = 4'b0010;
    reset = 1'b0;
    repeat (2) @(posedge clock);

    // add: IDLE needs start; then 1,2,3,5,1
    do_reset();
    step("idle_nostart", 0, I_ADD, 1, 0, 3'd0, C_OFF, 4'd0, 2'd0);
    step("idle_start",   1, I_ADD, 1, 0, 3'd0, C_OFF, 4'd0, 2'd0);
    run_alu("add", I_ADD, EX_R, 4'b0000);
    step("add_back", 0, I_ADD, 0, 0, 3'd1, F_WAIT, 4'd0, 2'd0);

    for (int i = 0; i < 4; i++) run_alu("rtype", rins[i], EX_R, ralu[i]);
    run_alu("ori", I_ORI, EX_I, 4'b0011);

    // bne taken and not taken
    step("bne0_f", 0, I_BNE, 1, 0, 3'd1, F_RDY, 4'd0, 2'd0);
    step("bne0_d", 0, I_BNE, 1, 0, 3'd2, DEC, 4'd0, 2'd0);
    step("bne0_e", 0, I_BNE, 1, 0, 3'd3, EX_BT, 4'b0001, 2'd0);
    step("bne1_f", 0, I_BNE, 1, 1, 3'd1, F_RDY, 4'd0, 2'd0);
    step("bne1_d", 0, I_BNE, 1, 1, 3'd2, DEC, 4'd0, 2'd0);
    step("bne1_e", 0, I_BNE, 1, 1, 3'd3, EX_BN, 4'b0001, 2'd0);

    // lb with three MEM wait cycles: 8 cycles FETCH..WB
    step("lb_f", 0, I_LB, 1, 0, 3'd1, F_RDY, 4'd0, 2'd0);
    step("lb_d", 0, I_LB, 1, 0, 3'd2, DEC, 4'd0, 2'd0);
    step("lb_e", 0, I_LB, 1, 0, 3'd3, EX_I, 4'b0000, 2'd0);
    for (int i = 0; i < 3; i++)
      step("lb_mwait", 0, I_LB, 0, 0, 3'd4, M_LB, 4'd0, 2'd0);
    step("lb_mrdy", 0, I_LB, 1, 0, 3'd4, M_LB, 4'd0, 2'd0);
    step("lb_w",    0, I_LB, 1, 0, 3'd5, WB_LB, 4'd0, 2'd0);

    // sb completes, then second sb reset mid-MEM
    step("sb_f", 0, I_SB, 1, 0, 3'd1, F_RDY, 4'd0, 2'd0);
    step("sb_d", 0, I_SB, 1, 0, 3'd2, DEC, 4'd0, 2'd0);
    step("sb_e", 0, I_SB, 1, 0, 3'd3, EX_I, 4'b0000, 2'd0);
    step("sb_m", 0, I_SB, 1, 0, 3'd4, M_SB_R, 4'd0, 2'd0);
    step("sb2_f", 0, I_SB, 1, 0, 3'd1, F_RDY, 4'd0, 2'd0);
    step("sb2_d", 0, I_SB, 1, 0, 3'd2, DEC, 4'd0, 2'd0);
    step("sb2_e", 0, I_SB, 0, 0, 3'd3, EX_I, 4'b0000, 2'd0);
    step("sb2_m", 0, I_SB, 0, 0, 3'd4, M_SB_W, 4'd0, 2'd0);
    @(posedge clock); #2;
    reset = 1'b0;
    push("sb2_async_rst", 3'd0, C_OFF, 4'd0, 2'd0);
    @(posedge clock); #1;
    reset = 1'b1;

    // fetch timeout after 16 waiting cycles
    do_reset();
    step("to_idle", 1, I_ADD, 0, 0, 3'd0, C_OFF, 4'd0, 2'd0);
    for (int i = 0; i < 16; i++)
      step("to_fwait", 0, I_ADD, 0, 0, 3'd1, F_WAIT, 4'd0, 2'd0);
    step("to_halt", 1, I_ADD, 1, 0, 3'd6, C_OFF, 4'd0, 2'd2);

    // illegal word, start ignored in HALT
    do_reset();
    step("ill_idle", 1, I_ILL, 1, 0, 3'd0, C_OFF, 4'd0, 2'd0);
    step("ill_f",    1, I_ILL, 1, 0, 3'd1, F_RDY, 4'd0, 2'd0);
    step("ill_d",    1, I_ILL, 1, 0, 3'd2, DEC, 4'd0, 2'd0);
    for (int i = 0; i < 5; i++)
      step("ill_halt", 1, I_ILL, 1, 0, 3'd6, C_OFF, 4'd0, 2'd1);

    // zero word halts without a fault
    do_reset();
    step("z_idle", 1, 32'd0, 1, 0, 3'd0, C_OFF, 4'd0, 2'd0);
    step("z_f",    0, 32'd0, 1, 0, 3'd1, F_RDY, 4'd0, 2'd0);
    step("z_d",    0, 32'd0, 1, 0, 3'd2, DEC, 4'd0, 2'd0);
    step("z_halt", 0, 32'd0, 1, 0, 3'd6, C_OFF, 4'd0, 2'd0);

`ifdef CONTROL_PERF_EN
    do_reset();
    step("perf_idle", 1, I_ADD, 1, 0, 3'd0, C_OFF, 4'd0, 2'd0);
    for (int i = 0; i < 3; i++) run_alu("perf_add", I_ADD, EX_R, 4'b0000);
    nxt_perf = 1'b1; nxt_cyc = 32'd12; nxt_ins = 32'd3;
    step("perf_end", 0, I_ADD, 0, 0, 3'd1, F_WAIT, 4'd0, 2'd0);
`endif

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clock);
    @(posedge clock);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
